// File: rtl/cnn_kernal.sv
// Two-stage signed dot-product kernel: CI lane-wise products registered in stage 1,
// summed at full precision and registered in stage 2, with a matching 2-deep valid pipe.
module cnn_kernal #(
    parameter int CI     = 3,
    parameter int OF_BW  = 16,
    parameter int W_BW   = 8,
    localparam int MUL_BW = OF_BW + W_BW
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_pooling_valid,
    input  logic [CI*OF_BW-1:0]      i_pooling,
    input  logic [CI*W_BW-1:0]       i_weight,
    output logic                     o_kernal_valid,
    output logic signed [MUL_BW+1:0] o_kernel
);

    localparam int SUM_BW = MUL_BW + 2;

    logic signed [MUL_BW-1:0] prod_d [CI];
    logic signed [MUL_BW-1:0] prod_q [CI];
    logic signed [SUM_BW-1:0] sum_d;
    logic signed [SUM_BW-1:0] kernel_q;
    logic                     v1_q;
    logic                     valid_q;

    // Both operands are sign-extended to MUL_BW before multiplying; the true
    // product always fits, so keeping the low MUL_BW bits is exact.
    always_comb begin
        for (int k = 0; k < CI; k++) begin
            prod_d[k] = MUL_BW'($signed(i_pooling[k*OF_BW +: OF_BW]))
                      * MUL_BW'($signed(i_weight[k*W_BW +: W_BW]));
        end
    end

    // NOTE: combinational accumulators get a default before the loop so no latch is inferred.
    always_comb begin
        sum_d = '0;
        for (int k = 0; k < CI; k++) begin
            sum_d = sum_d + SUM_BW'(prod_q[k]);
        end
    end

    // NOTE: the product array is small and must read as zero during reset, so it is
    // cleared element by element rather than left to power-up state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < CI; k++) begin
                prod_q[k] <= '0;
            end
        end else if (i_pooling_valid) begin
            for (int k = 0; k < CI; k++) begin
                prod_q[k] <= prod_d[k];
            end
        end
    end

    // NOTE: non-blocking assignments let v1_q and valid_q shift as one pipeline per edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1_q     <= 1'b0;
            valid_q  <= 1'b0;
            kernel_q <= '0;
        end else begin
            v1_q    <= i_pooling_valid;
            valid_q <= v1_q;
            if (v1_q) begin
                kernel_q <= sum_d;
            end
        end
    end

    assign o_kernal_valid = valid_q;
    assign o_kernel       = kernel_q;

endmodule

// File: tb/tb_cnn_kernal.sv
// Self-checking bench for cnn_kernal: directed vector table, randomized streaming
// against an integer dot-product model, and reset corner cases.
module tb_cnn_kernal;

    localparam int CI     = 3;
    localparam int OF_BW  = 16;
    localparam int W_BW   = 8;
    localparam int OUT_BW = OF_BW + W_BW + 2;

    logic                    clk;
    logic                    reset_n;
    logic                    i_pooling_valid;
    logic [CI*OF_BW-1:0]     i_pooling;
    logic [CI*W_BW-1:0]      i_weight;
    logic                    o_kernal_valid;
    logic signed [OUT_BW-1:0] o_kernel;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        int     pool [CI];
        int     wt   [CI];
        longint expect_val;
    } vec_t;

    cnn_kernal #(.CI(CI), .OF_BW(OF_BW), .W_BW(W_BW)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_pooling_valid (i_pooling_valid),
        .i_pooling       (i_pooling),
        .i_weight        (i_weight),
        .o_kernal_valid  (o_kernal_valid),
        .o_kernel        (o_kernel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic longint ref_dot(input int p [CI], input int w [CI]);
        longint s = 0;
        for (int k = 0; k < CI; k++) s += longint'(p[k]) * longint'(w[k]);
        return s;
    endfunction

    task automatic drive(input logic v, input int p [CI], input int w [CI]);
        int pv, wv;
        i_pooling_valid = v;
        for (int k = 0; k < CI; k++) begin
            pv = p[k];
            wv = w[k];
            i_pooling[k*OF_BW +: OF_BW] = pv[OF_BW-1:0];
            i_weight[k*W_BW +: W_BW]    = wv[W_BW-1:0];
        end
    endtask

    task automatic rand_lanes(output int p [CI], output int w [CI]);
        for (int k = 0; k < CI; k++) begin
            p[k] = int'($urandom_range(0, 65535)) - 32768;
            w[k] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic longint out_val();
        return longint'(o_kernel);
    endfunction

    vec_t   vecs [5];
    int     rp [CI];
    int     rw [CI];
    int     sp [24][CI];
    int     sw [24][CI];
    logic   sv [24];
    longint last_out;

    initial begin
        vecs[0] = '{pool: '{1, 2, 3},                wt: '{1, 1, 1},          expect_val: 6};
        vecs[1] = '{pool: '{100, -50, 7},            wt: '{-2, 3, -128},      expect_val: -1246};
        vecs[2] = '{pool: '{-32768, -32768, -32768}, wt: '{-128, -128, -128}, expect_val: 12582912};
        vecs[3] = '{pool: '{32767, 32767, 32767},    wt: '{-128, -128, -128}, expect_val: -12582528};
        vecs[4] = '{pool: '{-32768, 32767, 0},       wt: '{127, -128, -128},  expect_val: -8355712};

        // Reset held with toggling inputs: outputs stay cleared.
        reset_n = 1'b0;
        i_pooling_valid = 1'b0;
        i_pooling = '0;
        i_weight = '0;
        #1;
        check("reset_valid_t0", longint'(o_kernal_valid), 0);
        check("reset_kernel_t0", out_val(), 0);
        for (int c = 0; c < 5; c++) begin
            rand_lanes(rp, rw);
            drive(c[0] ? 1'b0 : 1'b1, rp, rw);
            step();
            check("reset_valid", longint'(o_kernal_valid), 0);
            check("reset_kernel", out_val(), 0);
        end
        rand_lanes(rp, rw);
        drive(1'b0, rp, rw);
        #2 reset_n = 1'b1;
        step();

        // Directed single beats: 2-cycle latency, 1-cycle valid pulse, held value after.
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].pool, vecs[i].wt);
            step();
            check("single_pre_valid", longint'(o_kernal_valid), 0);
            rand_lanes(rp, rw);
            drive(1'b0, rp, rw);
            step();
            check("single_valid", longint'(o_kernal_valid), 1);
            check("single_kernel", out_val(), vecs[i].expect_val);
            step();
            check("single_valid_drop", longint'(o_kernal_valid), 0);
            check("single_kernel_hold", out_val(), vecs[i].expect_val);
        end
        last_out = vecs[4].expect_val;

        // Randomized stream: 16 beats, 3-cycle gap, 4 beats, then drain.
        for (int c = 0; c < 24; c++) begin
            sv[c] = (c < 16) || (c >= 19 && c < 23);
            rand_lanes(rp, rw);
            sp[c] = rp;
            sw[c] = rw;
        end
        for (int c = 0; c < 26; c++) begin
            if (c < 24) drive(sv[c], sp[c], sw[c]);
            else begin
                rand_lanes(rp, rw);
                drive(1'b0, rp, rw);
            end
            step();
            // After edge c the output reflects the beat sampled at edge c-1.
            if (c >= 1) begin
                if (sv[c-1]) last_out = ref_dot(sp[c-1], sw[c-1]);
                check("stream_valid", longint'(o_kernal_valid), longint'(sv[c-1]));
                check("stream_kernel", out_val(), last_out);
            end
        end

        // Reset one cycle after a valid beat: async clear, beat discarded.
        drive(1'b1, vecs[1].pool, vecs[1].wt);
        step();
        check("midrst_pre_kernel", out_val(), last_out);
        rand_lanes(rp, rw);
        drive(1'b0, rp, rw);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_async_valid", longint'(o_kernal_valid), 0);
        check("midrst_async_kernel", out_val(), 0);
        step();
        step();
        #2 reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            check("midrst_no_ghost_valid", longint'(o_kernal_valid), 0);
            check("midrst_no_ghost_kernel", out_val(), 0);
        end

        // First beat after release uses the normal latency.
        drive(1'b1, vecs[0].pool, vecs[0].wt);
        step();
        check("post_rst_pre_valid", longint'(o_kernal_valid), 0);
        rand_lanes(rp, rw);
        drive(1'b0, rp, rw);
        step();
        check("post_rst_valid", longint'(o_kernal_valid), 1);
        check("post_rst_kernel", out_val(), vecs[0].expect_val);
        step();
        check("post_rst_valid_drop", longint'(o_kernal_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cnn_kernal.md
CNN_KERNAL -- requirements
Module: cnn_kernal

Interface
REQ-001 The module SHALL have the parameter CI, default 3, giving the number of input lanes (pooling values and weights) per dot product.
REQ-002 The module SHALL have the parameter OF_BW, default 16, giving the width of each signed pooling value.
REQ-003 The module SHALL have the parameter W_BW, default 8, giving the width of each signed weight.
REQ-004 The module SHALL use the derived constant MUL_BW = OF_BW + W_BW as the signed product width; the output width SHALL be MUL_BW + 2 (= 26 at defaults).
REQ-005 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 Port reset_n, input, 1 bit: one clock; reset is asynchronous and active-low.
REQ-007 Port i_pooling_valid, input, 1 bit: qualifies i_pooling and i_weight in the current cycle.
REQ-008 Port i_pooling, input, CI*OF_BW bits: lane k is i_pooling[k*OF_BW +: OF_BW], two's complement.
REQ-009 Port i_weight, input, CI*W_BW bits: lane k is i_weight[k*W_BW +: W_BW], two's complement.
REQ-010 Port o_kernal_valid, output, 1 bit: qualifies o_kernel.
REQ-011 Port o_kernel, output, MUL_BW+2 bits: signed dot product sum over k of i_pooling[k]*i_weight[k].

Function
REQ-012 Stage 1 SHALL compute CI signed products, each sign-extended to MUL_BW bits. Stage 1 SHALL register these products on every rising edge where i_pooling_valid=1.
REQ-013 Stage 1 SHALL hold the registered products when i_pooling_valid=0.
REQ-014 Stage 2 SHALL sign-extend each registered product to MUL_BW+2 bits and sum all CI products. Stage 2 SHALL register the sum into o_kernel on the edge after the stage-1 valid.
REQ-015 The arithmetic SHALL be exact: no overflow, saturation, rounding or truncation at any parameter value with CI<=4.
REQ-016 Latency SHALL be exactly 2 clock cycles. Inputs sampled at edge N SHALL produce o_kernal_valid=1 and the matching o_kernel after edge N+1, held until edge N+2.
REQ-017 The valid SHALL travel through a 2-stage shift register (v1 <= i_pooling_valid; o_kernal_valid <= v1), independent of data values.
REQ-018 There SHALL be no backpressure. A new input SHALL be accepted every cycle, and back-to-back valids SHALL give back-to-back outputs in order.
REQ-019 When o_kernal_valid=0, o_kernel SHALL hold its last computed value. Downstream logic SHALL use o_kernel only when o_kernal_valid=1.
REQ-020 There SHALL be no internal accumulation across samples; each output depends only on one input beat.
REQ-021 A gap in i_pooling_valid SHALL produce a gap of the same length in o_kernal_valid, two cycles later.

Reset
REQ-022 While reset_n=0, the product registers, v1, o_kernal_valid and o_kernel SHALL clear to 0 immediately, without waiting for a clock edge.
REQ-023 A reset asserted mid-pipeline SHALL discard all in-flight beats, so that no valid output appears for them after release.
REQ-024 The first beat accepted after reset release SHALL follow the normal 2-cycle latency.

Verification
REQ-025 Reset check: hold reset_n=0 with inputs toggling -> o_kernal_valid=0 and o_kernel=0 throughout.
REQ-026 Single beat: pooling lanes {1,2,3}, weights {1,1,1}, valid for 1 cycle -> o_kernel=6, with o_kernal_valid high for exactly 1 cycle, 2 cycles later.
REQ-027 Signed beat: pooling {100,-50,7}, weights {-2,3,-128} -> o_kernel=-200-150-896=-1246.
REQ-028 Extremes: all pooling lanes -32768, all weights -128 -> o_kernel=+12582912 with no wrap. All pooling lanes 32767 and all weights -128 -> -12582528.
REQ-029 Streaming: 16 consecutive valid beats with random data -> 16 consecutive valid outputs, each matching the reference dot product in order. A 3-cycle valid gap -> a 3-cycle output gap.
REQ-030 Reset mid-operation: assert reset_n=0 one cycle after a valid beat -> outputs clear asynchronously and no output appears for that beat after release.
